// File: rtl/cv32e40p_hwloop_sequencer.sv
// Hardware-loop sequencer: two loop register sets (start/end/count) and a
// two-state redirect FSM that sends fetch back to the loop start whenever
// the instruction retiring in ID is the last instruction of an active loop.
module cv32e40p_hwloop_sequencer #(
    parameter int N_REGSETS = 2,
    parameter int CNT_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [2:0]                       hwlp_we_i,
    input  logic                             hwlp_regid_i,
    input  logic [31:0]                      hwlp_start_data_i,
    input  logic [31:0]                      hwlp_end_data_i,
    input  logic [CNT_WIDTH-1:0]             hwlp_cnt_data_i,
    input  logic                             id_valid_i,
    input  logic [31:0]                      pc_id_i,
    input  logic                             fetch_ready_i,
    output logic                             hwlp_jump_o,
    output logic [31:0]                      hwlp_target_o,
    output logic [N_REGSETS*32-1:0]          hwlp_start_o,
    output logic [N_REGSETS*32-1:0]          hwlp_end_o,
    output logic [N_REGSETS*CNT_WIDTH-1:0]   hwlp_cnt_o,
    output logic                             hwlp_busy_o
);

    typedef enum logic {IDLE, JUMP} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t               state_q, state_d;
    logic [31:0]          target_q, target_d;
    logic [31:0]          start_q [N_REGSETS];
    logic [31:0]          start_d [N_REGSETS];
    logic [31:0]          end_q   [N_REGSETS];
    logic [31:0]          end_d   [N_REGSETS];
    logic [CNT_WIDTH-1:0] cnt_q   [N_REGSETS];
    logic [CNT_WIDTH-1:0] cnt_d   [N_REGSETS];

    logic hit0, hit1;
    logic sel_set;

    // A set hits when it is active (non-zero count) and its last instruction retires
    assign hit0 = id_valid_i && (cnt_q[0] != '0) && (pc_id_i == end_q[0]);
    assign hit1 = id_valid_i && (cnt_q[1] != '0) && (pc_id_i == end_q[1]);
    // Set 0 is the inner loop and wins when both sets end on the same address
    assign sel_set = hit0 ? 1'b0 : 1'b1;

    // Next-state logic: loop bookkeeping first, decoder writes last so they win
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        for (int i = 0; i < N_REGSETS; i++) begin
            start_d[i] = start_q[i];
            end_d[i]   = end_q[i];
            cnt_d[i]   = cnt_q[i];
        end

        case (state_q)
            IDLE: begin
                if (hit0 || hit1) begin
                    if (cnt_q[sel_set] > CNT_ONE) begin
                        cnt_d[sel_set] = cnt_q[sel_set] - CNT_ONE;
                        state_d        = JUMP;
                        target_d       = start_q[sel_set];
                    end else begin
                        // Last iteration: retire the loop and fall through
                        cnt_d[sel_set] = '0;
                    end
                end
            end
            JUMP: begin
                // Hold the redirect until fetch takes it; hits here are ignored
                if (fetch_ready_i) begin
                    state_d  = IDLE;
                    target_d = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                target_d = '0;
            end
        endcase

        if (hwlp_we_i[0]) start_d[hwlp_regid_i] = hwlp_start_data_i;
        if (hwlp_we_i[1]) end_d[hwlp_regid_i]   = hwlp_end_data_i;
        if (hwlp_we_i[2]) cnt_d[hwlp_regid_i]   = hwlp_cnt_data_i;
    end

    // State and loop registers; async reset aborts any pending redirect at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            for (int i = 0; i < N_REGSETS; i++) begin
                start_q[i] <= '0;
                end_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            for (int i = 0; i < N_REGSETS; i++) begin
                start_q[i] <= start_d[i];
                end_q[i]   <= end_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // target_q is only non-zero while in JUMP, so it drives the port directly
    assign hwlp_jump_o   = (state_q == JUMP);
    assign hwlp_busy_o   = (state_q == JUMP);
    assign hwlp_target_o = target_q;

    genvar g;
    generate
        for (g = 0; g < N_REGSETS; g++) begin : g_pack
            assign hwlp_start_o[g*32 +: 32]              = start_q[g];
            assign hwlp_end_o[g*32 +: 32]                = end_q[g];
            assign hwlp_cnt_o[g*CNT_WIDTH +: CNT_WIDTH]  = cnt_q[g];
        end
    endgenerate

endmodule

// File: tb/tb_cv32e40p_hwloop_sequencer.sv
// Directed bench for the hardware-loop sequencer.
module tb_cv32e40p_hwloop_sequencer;

    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    hwlp_we_i;
    logic          hwlp_regid_i;
    logic [31:0]   hwlp_start_data_i;
    logic [31:0]   hwlp_end_data_i;
    logic [CW-1:0] hwlp_cnt_data_i;
    logic          id_valid_i;
    logic [31:0]   pc_id_i;
    logic          fetch_ready_i;
    logic          hwlp_jump_o;
    logic [31:0]   hwlp_target_o;
    logic [63:0]   hwlp_start_o;
    logic [63:0]   hwlp_end_o;
    logic [2*CW-1:0] hwlp_cnt_o;
    logic          hwlp_busy_o;

    int n_checks = 0;
    int n_errors = 0;

    cv32e40p_hwloop_sequencer #(.N_REGSETS(2), .CNT_WIDTH(CW)) dut (
        .clk               (clk),
        .rst               (rst),
        .hwlp_we_i         (hwlp_we_i),
        .hwlp_regid_i      (hwlp_regid_i),
        .hwlp_start_data_i (hwlp_start_data_i),
        .hwlp_end_data_i   (hwlp_end_data_i),
        .hwlp_cnt_data_i   (hwlp_cnt_data_i),
        .id_valid_i        (id_valid_i),
        .pc_id_i           (pc_id_i),
        .fetch_ready_i     (fetch_ready_i),
        .hwlp_jump_o       (hwlp_jump_o),
        .hwlp_target_o     (hwlp_target_o),
        .hwlp_start_o      (hwlp_start_o),
        .hwlp_end_o        (hwlp_end_o),
        .hwlp_cnt_o        (hwlp_cnt_o),
        .hwlp_busy_o       (hwlp_busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic id, input logic [2:0] we, input logic [31:0] s,
                      input logic [31:0] e, input logic [CW-1:0] c);
        hwlp_regid_i      = id;
        hwlp_we_i         = we;
        hwlp_start_data_i = s;
        hwlp_end_data_i   = e;
        hwlp_cnt_data_i   = c;
        tick();
        hwlp_we_i = 3'b000;
    endtask

    task automatic retire(input logic [31:0] pc);
        id_valid_i = 1'b1;
        pc_id_i    = pc;
        tick();
        id_valid_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        hwlp_we_i = '0; hwlp_regid_i = 1'b0;
        hwlp_start_data_i = '0; hwlp_end_data_i = '0; hwlp_cnt_data_i = '0;
        id_valid_i = 1'b0; pc_id_i = '0; fetch_ready_i = 1'b1;
        tick();
        tick();
        chk("rst_jump",   {63'd0, hwlp_jump_o}, 64'd0);
        chk("rst_busy",   {63'd0, hwlp_busy_o}, 64'd0);
        chk("rst_target", {32'd0, hwlp_target_o}, 64'd0);
        chk("rst_cnt",    hwlp_cnt_o, 64'd0);
        rst = 1'b0;

        // Three-iteration loop on set 0
        wr(1'b0, 3'b111, 32'h100, 32'h10C, 32'd3);
        chk("prog_start0", {32'd0, hwlp_start_o[31:0]}, 64'h100);
        chk("prog_end0",   {32'd0, hwlp_end_o[31:0]}, 64'h10C);
        chk("prog_cnt0",   {32'd0, hwlp_cnt_o[31:0]}, 64'd3);
        retire(32'h10C);
        chk("l1_jump",   {63'd0, hwlp_jump_o}, 64'd1);
        chk("l1_target", {32'd0, hwlp_target_o}, 64'h100);
        chk("l1_cnt",    {32'd0, hwlp_cnt_o[31:0]}, 64'd2);
        tick();
        chk("l1_idle",   {63'd0, hwlp_jump_o}, 64'd0);
        chk("l1_tgt0",   {32'd0, hwlp_target_o}, 64'd0);
        retire(32'h10C);
        chk("l2_jump",   {63'd0, hwlp_jump_o}, 64'd1);
        chk("l2_cnt",    {32'd0, hwlp_cnt_o[31:0]}, 64'd1);
        tick();
        retire(32'h10C);
        chk("l3_nojump", {63'd0, hwlp_jump_o}, 64'd0);
        chk("l3_cnt",    {32'd0, hwlp_cnt_o[31:0]}, 64'd0);

        // Nested loops sharing an end address: set 0 wins, set 1 untouched
        wr(1'b0, 3'b111, 32'h200, 32'h20C, 32'd2);
        wr(1'b1, 3'b111, 32'h1F0, 32'h20C, 32'd5);
        retire(32'h20C);
        chk("nest_jump",   {63'd0, hwlp_jump_o}, 64'd1);
        chk("nest_target", {32'd0, hwlp_target_o}, 64'h200);
        chk("nest_cnt0",   {32'd0, hwlp_cnt_o[31:0]}, 64'd1);
        chk("nest_cnt1",   {32'd0, hwlp_cnt_o[63:32]}, 64'd5);
        tick();

        // Stalled fetch: redirect held for 4 cycles; start write must not move target
        wr(1'b0, 3'b100, 32'h0, 32'h0, 32'd3);
        fetch_ready_i = 1'b0;
        retire(32'h20C);
        for (int i = 0; i < 4; i++) begin
            chk("stall_jump",   {63'd0, hwlp_jump_o}, 64'd1);
            chk("stall_busy",   {63'd0, hwlp_busy_o}, 64'd1);
            chk("stall_target", {32'd0, hwlp_target_o}, 64'h200);
            if (i == 1) wr(1'b0, 3'b001, 32'h300, 32'h0, 32'd0);
            else if (i < 3) tick();
        end
        chk("stall_start0", {32'd0, hwlp_start_o[31:0]}, 64'h300);
        chk("stall_cnt0",   {32'd0, hwlp_cnt_o[31:0]}, 64'd2);
        fetch_ready_i = 1'b1;
        tick();
        chk("stall_clr_jump", {63'd0, hwlp_jump_o}, 64'd0);
        chk("stall_clr_busy", {63'd0, hwlp_busy_o}, 64'd0);

        // Write and hit on the same counter in the same cycle: write wins
        wr(1'b0, 3'b100, 32'h0, 32'h0, 32'd4);
        hwlp_we_i = 3'b100; hwlp_regid_i = 1'b0; hwlp_cnt_data_i = 32'd7;
        retire(32'h20C);
        hwlp_we_i = 3'b000;
        chk("wwin_cnt",    {32'd0, hwlp_cnt_o[31:0]}, 64'd7);
        chk("wwin_jump",   {63'd0, hwlp_jump_o}, 64'd1);
        chk("wwin_target", {32'd0, hwlp_target_o}, 64'h300);
        tick();

        // Asynchronous reset during JUMP
        fetch_ready_i = 1'b0;
        retire(32'h20C);
        chk("arst_pre_jump", {63'd0, hwlp_jump_o}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_jump",   {63'd0, hwlp_jump_o}, 64'd0);
        chk("arst_busy",   {63'd0, hwlp_busy_o}, 64'd0);
        chk("arst_target", {32'd0, hwlp_target_o}, 64'd0);
        tick();
        rst = 1'b0;
        fetch_ready_i = 1'b1;
        // First edge after release already takes a write (cnt stays 0)
        wr(1'b0, 3'b011, 32'h20, 32'h40, 32'd0);
        chk("rel_jump",  {63'd0, hwlp_jump_o}, 64'd0);
        chk("rel_start", hwlp_start_o, 64'h20);
        chk("rel_end",   hwlp_end_o, 64'h40);
        chk("rel_cnt",   hwlp_cnt_o, 64'd0);

        // Inactive set: pc == end with cnt 0 gives no redirect
        retire(32'h40);
        chk("zero_jump", {63'd0, hwlp_jump_o}, 64'd0);
        chk("zero_cnt",  {32'd0, hwlp_cnt_o[31:0]}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
